// File: rtl/hw_trigger_unit.sv
// rtl/hw_trigger_unit.sv - Sdtrig mcontrol trigger slots with CSR access and debug/breakpoint requests
// Optional feature macro: TRIG_ICOUNT_EN (slot 0 may also be programmed as an icount trigger).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module hw_trigger_unit #(
   parameter int NUM_TRIG = 2,
   parameter int XLEN     = `DATA_WIDTH
) (
   input  logic                cpu_clk_i,
   input  logic                cpu_rstn_i,
   input  logic                dbg_mode_i,
   input  logic                csr_wr_en_i,
   input  logic [11:0]         csr_addr_i,
   input  logic [XLEN-1:0]     csr_wr_data_i,
   output logic [XLEN-1:0]     csr_rd_data_o,
   input  logic [XLEN-1:0]     pc_ex_i,
   input  logic                pc_ex_vld_i,
   input  logic [XLEN-1:0]     mem_addr_ex_i,
   input  logic                load_ex_i,
   input  logic                store_ex_i,
   input  logic                instr_retire_i,
   output logic                breakpoint_o,
   output logic                breakpoint_exp_o,
   output logic [NUM_TRIG-1:0] trig_hit_o
);
   localparam int TSW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
   localparam logic [11:0] A_TSELECT = 12'h7A0;
   localparam logic [11:0] A_TDATA1  = 12'h7A1;
   localparam logic [11:0] A_TDATA2  = 12'h7A2;

   logic [TSW-1:0]                 tselect_q;
   logic [NUM_TRIG-1:0]            dmode_q, hit_q, timing_q, chain_q, m_q, exe_q, st_q, ld_q;
   logic [NUM_TRIG-1:0][3:0]       action_q, match_q;
   logic [NUM_TRIG-1:0][XLEN-1:0]  tdata2_q;
   logic                           bp_q, exc_q;
   logic                           bp_d, exc_d;
   logic [NUM_TRIG-1:0]            fire_d;
   logic                           qual, grp, mem_sel;
   logic [XLEN-1:0]                rd_t1;
   logic [3:0]                     wr_type;
   logic                           wr_ok;
`ifdef TRIG_ICOUNT_EN
   logic                           icount_q;
   logic [13:0]                    count_q;
`else
   logic                           unused_retire;
   assign unused_retire = instr_retire_i;
`endif

   // NAPOT: the low k+1 bits are don't-care, k = trailing ones of tdata2
   function automatic logic addr_cmp(input logic [3:0] mode, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] t);
      logic [XLEN-1:0] care;
      care = ~(t ^ (t + XLEN'(1)));
      case (mode)
         4'd0:    addr_cmp = (a == t);
         4'd1:    addr_cmp = ((a & care) == (t & care));
         4'd2:    addr_cmp = (a >= t);
         4'd3:    addr_cmp = (a < t);
         default: addr_cmp = 1'b0;
      endcase
   endfunction

   // qual carries "previous slot of the chain matched" into the next slot
   always_comb begin
      fire_d  = '0;
      qual    = 1'b1;
      grp     = 1'b0;
      mem_sel = 1'b0;
      bp_d    = 1'b0;
      exc_d   = 1'b0;
      for (int i = 0; i < NUM_TRIG; i++) begin
         mem_sel = (ld_q[i] && load_ex_i) || (st_q[i] && store_ex_i);
         grp = qual && m_q[i] &&
               ((exe_q[i] && pc_ex_vld_i && addr_cmp(match_q[i], pc_ex_i, tdata2_q[i])) ||
                (mem_sel && addr_cmp(match_q[i], mem_addr_ex_i, tdata2_q[i])));
         fire_d[i] = grp && !dbg_mode_i && ((i == NUM_TRIG - 1) || !chain_q[i]);
         qual = chain_q[i] ? grp : 1'b1;
      end
`ifdef TRIG_ICOUNT_EN
      if (icount_q && instr_retire_i && !dbg_mode_i && count_q == 14'd1)
         fire_d[0] = 1'b1;
`endif
      for (int i = 0; i < NUM_TRIG; i++) begin
         if (fire_d[i] && action_q[i] == 4'd1 && dmode_q[i]) bp_d = 1'b1;
         if (fire_d[i] && action_q[i] == 4'd0) exc_d = 1'b1;
      end
      if (bp_d) exc_d = 1'b0;
   end

   always_comb begin
      rd_t1                = '0;
      rd_t1[XLEN-1 -: 4]   = 4'd2;
      rd_t1[XLEN-5]        = dmode_q[tselect_q];
      rd_t1[XLEN-6 -: 6]   = 6'd63;
      rd_t1[20]            = hit_q[tselect_q];
      rd_t1[18]            = timing_q[tselect_q];
      rd_t1[15:12]         = action_q[tselect_q];
      rd_t1[11]            = chain_q[tselect_q];
      rd_t1[10:7]          = match_q[tselect_q];
      rd_t1[6]             = m_q[tselect_q];
      rd_t1[2]             = exe_q[tselect_q];
      rd_t1[1]             = st_q[tselect_q];
      rd_t1[0]             = ld_q[tselect_q];
`ifdef TRIG_ICOUNT_EN
      if (icount_q && tselect_q == '0) begin
         rd_t1              = '0;
         rd_t1[XLEN-1 -: 4] = 4'd3;
         rd_t1[XLEN-5]      = dmode_q[0];
         rd_t1[24]          = hit_q[0];
         rd_t1[23:10]       = count_q;
         rd_t1[3:0]         = action_q[0];
      end
`endif
   end

   always_comb begin
      case (csr_addr_i)
         A_TSELECT: csr_rd_data_o = XLEN'(tselect_q);
         A_TDATA1:  csr_rd_data_o = rd_t1;
         A_TDATA2:  csr_rd_data_o = tdata2_q[tselect_q];
         default:   csr_rd_data_o = '0;
      endcase
   end

   assign wr_type = csr_wr_data_i[XLEN-1 -: 4];
   assign wr_ok   = !(dmode_q[tselect_q] && !dbg_mode_i);

   always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
      if (!cpu_rstn_i) begin
         tselect_q <= '0;
         dmode_q   <= '0;
         hit_q     <= '0;
         timing_q  <= '0;
         chain_q   <= '0;
         m_q       <= '0;
         exe_q     <= '0;
         st_q      <= '0;
         ld_q      <= '0;
         action_q  <= '0;
         match_q   <= '0;
         tdata2_q  <= '0;
         bp_q      <= 1'b0;
         exc_q     <= 1'b0;
`ifdef TRIG_ICOUNT_EN
         icount_q  <= 1'b0;
         count_q   <= '0;
`endif
      end else begin
         bp_q  <= bp_d;
         exc_q <= exc_d;
`ifdef TRIG_ICOUNT_EN
         if (icount_q && instr_retire_i && !dbg_mode_i && count_q != '0)
            count_q <= count_q - 14'd1;
`endif
         if (csr_wr_en_i) begin
            if (csr_addr_i == A_TSELECT && csr_wr_data_i < XLEN'(NUM_TRIG))
               tselect_q <= csr_wr_data_i[TSW-1:0];
            if (wr_ok && csr_addr_i == A_TDATA2)
               tdata2_q[tselect_q] <= csr_wr_data_i;
            if (wr_ok && csr_addr_i == A_TDATA1 && wr_type == 4'd2) begin
               dmode_q[tselect_q]  <= dbg_mode_i & csr_wr_data_i[XLEN-5];
               hit_q[tselect_q]    <= csr_wr_data_i[20];
               timing_q[tselect_q] <= csr_wr_data_i[18];
               action_q[tselect_q] <= csr_wr_data_i[15:12];
               chain_q[tselect_q]  <= csr_wr_data_i[11];
               match_q[tselect_q]  <= csr_wr_data_i[10:7];
               m_q[tselect_q]      <= csr_wr_data_i[6];
               exe_q[tselect_q]    <= csr_wr_data_i[2];
               st_q[tselect_q]     <= csr_wr_data_i[1];
               ld_q[tselect_q]     <= csr_wr_data_i[0];
`ifdef TRIG_ICOUNT_EN
               if (tselect_q == '0) icount_q <= 1'b0;
`endif
            end
`ifdef TRIG_ICOUNT_EN
            if (wr_ok && csr_addr_i == A_TDATA1 && wr_type == 4'd3 && tselect_q == '0) begin
               icount_q    <= 1'b1;
               dmode_q[0]  <= dbg_mode_i & csr_wr_data_i[XLEN-5];
               hit_q[0]    <= csr_wr_data_i[24];
               count_q     <= csr_wr_data_i[23:10];
               action_q[0] <= csr_wr_data_i[3:0];
               chain_q[0]  <= 1'b0;
               m_q[0]      <= 1'b0;
               exe_q[0]    <= 1'b0;
               st_q[0]     <= 1'b0;
               ld_q[0]     <= 1'b0;
            end
`endif
         end
         for (int i = 0; i < NUM_TRIG; i++)
            if (fire_d[i]) hit_q[i] <= 1'b1;
      end
   end

   assign breakpoint_o     = bp_q;
   assign breakpoint_exp_o = exc_q;
   assign trig_hit_o       = hit_q;

endmodule

// File: tb/tb_hw_trigger_unit.sv
// tb/tb_hw_trigger_unit.sv - scoreboard bench for hw_trigger_unit (NUM_TRIG=2, XLEN=32)
module tb_hw_trigger_unit;
   logic        clk = 1'b0, rstn = 1'b0, dbg = 1'b0, wr_en = 1'b0;
   logic [11:0] addr = '0;
   logic [31:0] wdata = '0, rdata, pc = '0, ma = '0;
   logic        vld = 1'b0, ld = 1'b0, st = 1'b0, ret = 1'b0, bp, exc;
   logic [1:0]  hit;
   int          n_checks = 0, n_fail = 0;
   string       sb_tag[$];
   logic [3:0]  sb_val[$];

   hw_trigger_unit #(.NUM_TRIG(2), .XLEN(32)) dut (
      .cpu_clk_i(clk), .cpu_rstn_i(rstn), .dbg_mode_i(dbg), .csr_wr_en_i(wr_en),
      .csr_addr_i(addr), .csr_wr_data_i(wdata), .csr_rd_data_o(rdata),
      .pc_ex_i(pc), .pc_ex_vld_i(vld), .mem_addr_ex_i(ma), .load_ex_i(ld), .store_ex_i(st),
      .instr_retire_i(ret), .breakpoint_o(bp), .breakpoint_exp_o(exc), .trig_hit_o(hit));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // mcontrol word with m=1: dmode, action, chain, match, execute, store, load
   function automatic logic [31:0] mc(input logic dm, input logic [3:0] act, input logic ch,
                                      input logic [3:0] mt, input logic ex, input logic s, input logic l);
      mc = 32'h2000_0040 | (32'(dm) << 27) | (32'(act) << 12) | (32'(ch) << 11) | (32'(mt) << 7)
           | (32'(ex) << 2) | (32'(s) << 1) | 32'(l);
   endfunction

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk); #1;
      addr = a; wdata = d; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] e);
      addr = a; #1;
      check_eq(tag, rdata, e);
   endtask

   // e = {trig_hit[1:0], breakpoint, breakpoint_exp} expected after this cycle's edge
   task automatic cyc(input string tag, input logic [31:0] p, input logic v, input logic [31:0] m,
                      input logic l, input logic s, input logic r, input logic [3:0] e);
      @(negedge clk); #1;
      pc = p; vld = v; ma = m; ld = l; st = s; ret = r;
      sb_tag.push_back(tag);
      sb_val.push_back(e);
      @(posedge clk); #1;
      vld = 1'b0; ld = 1'b0; st = 1'b0; ret = 1'b0; wr_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sb_val.size() > 0) begin
         string t;
         logic [3:0] v;
         t = sb_tag.pop_front();
         v = sb_val.pop_front();
         check_eq(t, 32'({hit, bp, exc}), 32'(v));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_outputs", 32'({hit, bp, exc}), 32'h0);
      rd_chk("rst_tselect", 12'h7A0, 32'h0);
      rd_chk("rst_tdata1", 12'h7A1, 32'h27E0_0000);
      rd_chk("rst_tdata2", 12'h7A2, 32'h0);
      rd_chk("rd_other_addr", 12'h300, 32'h0);
      @(negedge clk); rstn = 1'b1;

      // exact execute match
      csr_wr(12'h7A2, 32'h100);
      csr_wr(12'h7A1, mc(0, 0, 0, 0, 1, 0, 0));
      rd_chk("exact_tdata1", 12'h7A1, 32'h27E0_0044);
      cyc("exact_novld", 32'h100, 0, 0, 0, 0, 0, 4'b00_00);
      cyc("exact_miss",  32'h104, 1, 0, 0, 0, 0, 4'b00_00);
      cyc("exact_hit",   32'h100, 1, 0, 0, 0, 0, 4'b01_01);
      cyc("exact_pulse_end", 0, 0, 0, 0, 0, 0, 4'b01_00);
      rd_chk("exact_hitbit", 12'h7A1, 32'h27F0_0044);

      // NAPOT load, 16-byte region at 0x2000
      csr_wr(12'h7A2, 32'h2007);
      csr_wr(12'h7A1, mc(0, 0, 0, 1, 0, 0, 1));
      cyc("napot_out",   0, 0, 32'h2010, 1, 0, 0, 4'b00_00);
      cyc("napot_in",    0, 0, 32'h200C, 1, 0, 0, 4'b01_01);
      cyc("napot_base",  0, 0, 32'h2000, 1, 0, 0, 4'b01_01);
      cyc("napot_store", 0, 0, 32'h2004, 0, 1, 0, 4'b01_00);
      cyc("napot_exec",  32'h2004, 1, 0, 0, 0, 0, 4'b01_00);

      // chain: slot0 >= 0x1000 qualifies slot1 < 0x2000
      csr_wr(12'h7A2, 32'h1000);
      csr_wr(12'h7A1, mc(0, 0, 1, 2, 0, 1, 0));
      csr_wr(12'h7A0, 32'd1);
      csr_wr(12'h7A2, 32'h2000);
      csr_wr(12'h7A1, mc(0, 0, 0, 3, 0, 1, 0));
      csr_wr(12'h7A0, 32'd2);
      rd_chk("tselect_oob", 12'h7A0, 32'd1);
      cyc("chain_in",  0, 0, 32'h1800, 0, 1, 0, 4'b10_01);
      cyc("chain_hi",  0, 0, 32'h2800, 0, 1, 0, 4'b10_00);
      cyc("chain_lo",  0, 0, 32'h0800, 0, 1, 0, 4'b10_00);

      // dmode protection
      csr_wr(12'h7A1, mc(0, 0, 0, 0, 0, 0, 0));
      csr_wr(12'h7A1, mc(1, 0, 0, 0, 0, 0, 0));
      rd_chk("dmode_set_denied", 12'h7A1, 32'h27E0_0040);
      dbg = 1'b1;
      csr_wr(12'h7A0, 32'd0);
      csr_wr(12'h7A2, 32'h300);
      csr_wr(12'h7A1, mc(1, 1, 0, 0, 1, 0, 0));
      rd_chk("dmode_set_dbg", 12'h7A1, 32'h2FE0_1044);
      dbg = 1'b0;
      csr_wr(12'h7A2, 32'h400);
      rd_chk("dmode_t2_locked", 12'h7A2, 32'h300);
      csr_wr(12'h7A1, mc(0, 0, 0, 0, 1, 0, 0));
      rd_chk("dmode_t1_locked", 12'h7A1, 32'h2FE0_1044);
      cyc("dmode_bp",  32'h300, 1, 0, 0, 0, 0, 4'b01_10);
      cyc("dmode_end", 0, 0, 0, 0, 0, 0, 4'b01_00);

      // priority, debug-mode drop, action=1 without dmode, write/match same cycle
      csr_wr(12'h7A0, 32'd1);
      csr_wr(12'h7A2, 32'h300);
      csr_wr(12'h7A1, mc(0, 0, 0, 0, 1, 0, 0));
      cyc("prio_bp_only", 32'h300, 1, 0, 0, 0, 0, 4'b11_10);
      dbg = 1'b1;
      csr_wr(12'h7A0, 32'd0);
      csr_wr(12'h7A1, mc(1, 1, 0, 0, 1, 0, 0));
      csr_wr(12'h7A0, 32'd1);
      csr_wr(12'h7A1, mc(0, 0, 0, 0, 1, 0, 0));
      cyc("dbg_block", 32'h300, 1, 0, 0, 0, 0, 4'b00_00);
      dbg = 1'b0;
      cyc("dbg_dropped", 0, 0, 0, 0, 0, 0, 4'b00_00);
      csr_wr(12'h7A2, 32'h500);
      csr_wr(12'h7A1, mc(0, 1, 0, 0, 1, 0, 0));
      cyc("act1_nodmode", 32'h500, 1, 0, 0, 0, 0, 4'b10_00);
      csr_wr(12'h7A1, mc(0, 0, 0, 0, 1, 0, 0));
      addr = 12'h7A2; wdata = 32'h600; wr_en = 1'b1;
      cyc("wr_old_value", 32'h500, 1, 0, 0, 0, 0, 4'b10_01);
      cyc("wr_new_miss",  32'h500, 1, 0, 0, 0, 0, 4'b10_00);
      cyc("wr_new_hit",   32'h600, 1, 0, 0, 0, 0, 4'b10_01);

      // asynchronous reset while a pulse is high
      @(negedge clk); #1;
      pc = 32'h600; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      check_eq("rst_pre_pulse", 32'({bp, exc}), 32'b01);
      #2 rstn = 1'b0; #1;
      check_eq("rst_async", 32'({hit, bp, exc}), 32'h0);
      rd_chk("rst_tdata1_again", 12'h7A1, 32'h27E0_0000);
      @(negedge clk); rstn = 1'b1;

`ifdef TRIG_ICOUNT_EN
      csr_wr(12'h7A1, 32'h3000_0C00);
      rd_chk("icnt_tdata1", 12'h7A1, 32'h3000_0C00);
      cyc("icnt_r1", 0, 0, 0, 0, 0, 1, 4'b00_00);
      cyc("icnt_r2", 0, 0, 0, 0, 0, 1, 4'b00_00);
      cyc("icnt_r3", 0, 0, 0, 0, 0, 1, 4'b01_01);
      cyc("icnt_r4", 0, 0, 0, 0, 0, 1, 4'b01_00);
      csr_wr(12'h7A1, 32'h3000_0C00);
      cyc("icnt_pre_rst", 0, 0, 0, 0, 0, 1, 4'b00_00);
      @(negedge clk); rstn = 1'b0;
      @(negedge clk); rstn = 1'b1;
      rd_chk("icnt_rst_tdata1", 12'h7A1, 32'h27E0_0000);
      for (int i = 0; i < 3; i++) cyc("icnt_after_rst", 0, 0, 0, 0, 0, 1, 4'b00_00);
`else
      csr_wr(12'h7A1, 32'h3000_0C00);
      rd_chk("icnt_ignored", 12'h7A1, 32'h27E0_0000);
      for (int i = 0; i < 3; i++) cyc("icnt_no_fire", 0, 0, 0, 0, 0, 1, 4'b00_00);
`endif

      repeat (2) @(negedge clk);
      check_eq("sb_drain", 32'(sb_val.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
